// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: 1-cycle payload latency, valid/ready on both sides.
// Load-use hazards stall ID (in_ready low) until the load result can be forwarded.
module id_ex_stage #(
  parameter int XLEN    = 64,
  parameter int REGID_W = 5,
  parameter int ALUOP_W = 5,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [REGID_W-1:0] in_rs1,
  input  logic [REGID_W-1:0] in_rs2,
  input  logic [XLEN-1:0]    in_rdata1,
  input  logic [XLEN-1:0]    in_rdata2,
  input  logic [XLEN-1:0]    in_imm,
  input  logic [REGID_W-1:0] in_rd,
  input  logic               in_wen,
  input  logic               in_is_load,
  input  logic [ALUOP_W-1:0] in_alu_op,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [REGID_W-1:0] out_rs1,
  output logic [REGID_W-1:0] out_rs2,
  output logic [XLEN-1:0]    out_rdata1,
  output logic [XLEN-1:0]    out_rdata2,
  output logic [XLEN-1:0]    out_imm,
  output logic [REGID_W-1:0] out_rd,
  output logic               out_wen,
  output logic               out_is_load,
  output logic [ALUOP_W-1:0] out_alu_op,
  output logic               lu_stall,
  output logic [CNT_W-1:0]   stall_cnt
);

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [REGID_W-1:0] rs1;
    logic [REGID_W-1:0] rs2;
    logic [XLEN-1:0]    rdata1;
    logic [XLEN-1:0]    rdata2;
    logic [XLEN-1:0]    imm;
    logic [REGID_W-1:0] rd;
    logic               wen;
    logic               is_load;
    logic [ALUOP_W-1:0] alu_op;
  } payload_t;

  payload_t           in_p;
  payload_t           out_q;
  logic               valid_q;
  logic               lu_pend;
  logic [REGID_W-1:0] lu_rd;
  logic [CNT_W-1:0]   cnt_q;

  logic acc;
  logic dep;
  logic hz;
  logic ex_load_hz;
  logic pend_hz;
  logic load_leaves;

  always_comb begin
    in_p         = '0;
    in_p.pc      = in_pc;
    in_p.rs1     = in_rs1;
    in_p.rs2     = in_rs2;
    in_p.rdata1  = in_rdata1;
    in_p.rdata2  = in_rdata2;
    in_p.imm     = in_imm;
    in_p.rd      = in_rd;
    in_p.wen     = in_wen;
    in_p.is_load = in_is_load;
    in_p.alu_op  = in_alu_op;
  end

  function automatic logic src_match(input logic [REGID_W-1:0] r,
                                     input logic [REGID_W-1:0] s1,
                                     input logic [REGID_W-1:0] s2);
    return (r != '0) && ((s1 == r) || (s2 == r));
  endfunction

  // A load in EX, or one that left last cycle, has no data to forward yet.
  assign ex_load_hz = valid_q & out_q.is_load & out_q.wen & src_match(out_q.rd, in_rs1, in_rs2);
  assign pend_hz    = lu_pend & src_match(lu_rd, in_rs1, in_rs2);
  assign hz         = in_valid & (ex_load_hz | pend_hz);

  assign in_ready    = rst_n & ~flush & ~hz & (~valid_q | out_ready);
  assign acc         = in_valid & in_ready;
  assign dep         = valid_q & out_ready;
  assign lu_stall    = hz & ~flush;
  assign load_leaves = dep & out_q.is_load & out_q.wen & (out_q.rd != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      out_q   <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (acc) begin
      valid_q <= 1'b1;
      out_q   <= in_p;
    end else if (dep) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_pend <= 1'b0;
      lu_rd   <= '0;
    end else begin
      lu_pend <= ~flush & load_leaves;
      if (load_leaves) lu_rd <= out_q.rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (lu_stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign out_valid   = valid_q;
  assign out_pc      = out_q.pc;
  assign out_rs1     = out_q.rs1;
  assign out_rs2     = out_q.rs2;
  assign out_rdata1  = out_q.rdata1;
  assign out_rdata2  = out_q.rdata2;
  assign out_imm     = out_q.imm;
  assign out_rd      = out_q.rd;
  assign out_wen     = out_q.wen;
  assign out_is_load = out_q.is_load;
  assign out_alu_op  = out_q.alu_op;
  assign stall_cnt   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: handshakes, load-use stalls, flush and async reset.
module tb_id_ex_stage;
  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic [63:0] in_pc, in_rdata1, in_rdata2, in_imm;
  logic [4:0]  in_rs1, in_rs2, in_rd, in_alu_op;
  logic        in_wen, in_is_load, flush;
  logic        out_valid, out_ready;
  logic [63:0] out_pc, out_rdata1, out_rdata2, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd, out_alu_op;
  logic        out_wen, out_is_load, lu_stall;
  logic [31:0] stall_cnt;

  int vectors = 0;
  int errors  = 0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rdata1(in_rdata1), .in_rdata2(in_rdata2), .in_imm(in_imm),
    .in_rd(in_rd), .in_wen(in_wen), .in_is_load(in_is_load), .in_alu_op(in_alu_op),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rdata1(out_rdata1), .out_rdata2(out_rdata2), .out_imm(out_imm),
    .out_rd(out_rd), .out_wen(out_wen), .out_is_load(out_is_load), .out_alu_op(out_alu_op),
    .lu_stall(lu_stall), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] pc, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic wen,
                       input logic ld, input logic [4:0] op, input logic [63:0] imm);
    in_valid = v; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_wen = wen; in_is_load = ld; in_alu_op = op; in_imm = imm;
    in_rdata1 = pc ^ 64'hA5A5; in_rdata2 = pc ^ 64'h5A5A;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b1, 64'h10, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 5'd1, 64'h0);
    #2;
    vectors++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++;
    if (out_pc !== 64'h0 || out_rd !== 5'd0 || out_imm !== 64'h0) begin
      errors++; $display("FAIL reset_payload: pc %h rd %0d imm %h want 0", out_pc, out_rd, out_imm);
    end
    vectors++;
    if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
    vectors++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 64'h1000 + 64'(4*i), 5'd1, 5'd2, 5'(3+i), 1'b1, 1'b0, 5'd2, 64'(i));
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready); end
      if (i > 0) begin
        vectors++;
        if (out_valid !== 1'b1 || out_pc !== 64'h1000 + 64'(4*(i-1))) begin
          errors++; $display("FAIL b2b_out_pc[%0d]: valid %b pc %h want 1 %h", i, out_valid, out_pc, 64'h1000 + 64'(4*(i-1)));
        end
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    vectors++;
    if (out_pc !== 64'h1010 || out_rd !== 5'd7 || out_rdata1 !== (64'h1010 ^ 64'hA5A5)) begin
      errors++; $display("FAIL b2b_last: pc %h rd %0d rdata1 %h want 1010 7 %h", out_pc, out_rd, out_rdata1, 64'h1010 ^ 64'hA5A5);
    end
    vectors++;
    if (stall_cnt !== 32'd0) begin errors++; $display("FAIL b2b_stall_cnt: got %0d want 0", stall_cnt); end
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: out_valid %b want 0", out_valid); end
  endtask

  task automatic test_load_use();
    out_ready = 1'b1;
    drive(1'b1, 64'h2000, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 5'd0, 64'h8);
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_accept_ld: in_ready %b want 1", in_ready); end
    tick();
    drive(1'b1, 64'h2004, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 5'd0, 64'h0);
    #1;
    vectors++;
    if (out_valid !== 1'b1 || out_pc !== 64'h2000 || in_ready !== 1'b0 || lu_stall !== 1'b1) begin
      errors++; $display("FAIL lu_cycle1: valid %b pc %h rdy %b stall %b want 1 2000 0 1", out_valid, out_pc, in_ready, lu_stall);
    end
    tick();
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || lu_stall !== 1'b1) begin
      errors++; $display("FAIL lu_cycle2: valid %b rdy %b stall %b want 0 0 1", out_valid, in_ready, lu_stall);
    end
    tick();
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || lu_stall !== 1'b0 || stall_cnt !== 32'd2) begin
      errors++; $display("FAIL lu_cycle3: valid %b rdy %b stall %b cnt %0d want 0 1 0 2", out_valid, in_ready, lu_stall, stall_cnt);
    end
    tick();
    in_valid = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b1 || out_pc !== 64'h2004 || out_rs1 !== 5'd5) begin
      errors++; $display("FAIL lu_add_out: valid %b pc %h rs1 %0d want 1 2004 5", out_valid, out_pc, out_rs1);
    end
    tick();
  endtask

  task automatic test_no_hazard_cases();
    out_ready = 1'b1;
    // ld x0 then add x6,x0,x0, followed by a wen=0 load and a reader of its rd
    drive(1'b1, 64'h3000, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 64'h0);
    tick();
    drive(1'b1, 64'h3004, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 5'd0, 64'h0);
    #1;
    vectors++;
    if (in_ready !== 1'b1 || lu_stall !== 1'b0 || out_pc !== 64'h3000) begin
      errors++; $display("FAIL x0_no_stall: rdy %b stall %b pc %h want 1 0 3000", in_ready, lu_stall, out_pc);
    end
    tick();
    drive(1'b1, 64'h3008, 5'd1, 5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 64'h0);
    #1;
    vectors++;
    if (out_valid !== 1'b1 || out_pc !== 64'h3004 || in_ready !== 1'b1) begin
      errors++; $display("FAIL x0_no_bubble: valid %b pc %h rdy %b want 1 3004 1", out_valid, out_pc, in_ready);
    end
    tick();
    drive(1'b1, 64'h300C, 5'd7, 5'd7, 5'd8, 1'b1, 1'b0, 5'd0, 64'h0);
    #1;
    vectors++;
    if (in_ready !== 1'b1 || lu_stall !== 1'b0 || stall_cnt !== 32'd2) begin
      errors++; $display("FAIL wen0_load: rdy %b stall %b cnt %0d want 1 0 2", in_ready, lu_stall, stall_cnt);
    end
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 64'h4000, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 5'd3, 64'h55);
    tick();
    drive(1'b1, 64'h4004, 5'd9, 5'd2, 5'd10, 1'b1, 1'b0, 5'd4, 64'h66);
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== 64'h4000 || out_imm !== 64'h55 || out_alu_op !== 5'd3 ||
          in_ready !== 1'b0 || lu_stall !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d]: valid %b pc %h imm %h op %0d rdy %b stall %b want 1 4000 55 3 0 0",
                           i, out_valid, out_pc, out_imm, out_alu_op, in_ready, lu_stall);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_resume: in_ready %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b1 || out_pc !== 64'h4004 || out_imm !== 64'h66) begin
      errors++; $display("FAIL bp_next: valid %b pc %h imm %h want 1 4004 66", out_valid, out_pc, out_imm);
    end
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    drive(1'b1, 64'h5000, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 5'd0, 64'h0);
    tick();
    out_ready = 1'b0;
    drive(1'b1, 64'h5004, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 5'd0, 64'h0);
    #1;
    vectors++;
    if (lu_stall !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_pre_stall: stall %b rdy %b want 1 0", lu_stall, in_ready);
    end
    tick();
    out_ready = 1'b1;
    flush = 1'b1;
    #1;
    vectors++;
    if (lu_stall !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_cycle: stall %b rdy %b want 0 0", lu_stall, in_ready);
    end
    tick();
    flush = 1'b0;
    drive(1'b1, 64'h6000, 5'd5, 5'd5, 5'd11, 1'b1, 1'b0, 5'd0, 64'h0);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || lu_stall !== 1'b0 || stall_cnt !== 32'd3) begin
      errors++; $display("FAIL flush_after: valid %b rdy %b stall %b cnt %0d want 0 1 0 3", out_valid, in_ready, lu_stall, stall_cnt);
    end
    tick();
    in_valid = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b1 || out_pc !== 64'h6000) begin
      errors++; $display("FAIL flush_new_pc: valid %b pc %h want 1 6000", out_valid, out_pc);
    end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b1;
    drive(1'b1, 64'h7000, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 5'd0, 64'h0);
    tick();
    drive(1'b1, 64'h7004, 5'd2, 5'd5, 5'd6, 1'b1, 1'b0, 5'd0, 64'h0);
    #1;
    vectors++;
    if (lu_stall !== 1'b1 || out_valid !== 1'b1) begin
      errors++; $display("FAIL rst_pre: stall %b valid %b want 1 1", lu_stall, out_valid);
    end
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || lu_stall !== 1'b0 || stall_cnt !== 32'd0 || in_ready !== 1'b0 || out_pc !== 64'h0) begin
      errors++; $display("FAIL rst_async: valid %b stall %b cnt %0d rdy %b pc %h want 0 0 0 0 0",
                         out_valid, lu_stall, stall_cnt, in_ready, out_pc);
    end
    tick();
    rst_n = 1'b1;
    #1;
    vectors++;
    if (lu_stall !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_release: stall %b rdy %b want 0 1", lu_stall, in_ready);
    end
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_use();
    test_no_hazard_cases();
    test_backpressure();
    test_flush();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
